// File: rtl/dma_regfile_pkg.sv
// Shared constants and types for the DMA control/status register file.
package dma_regfile_pkg;

    localparam int ADDR_ID     = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_MASK   = 2;

    localparam logic [31:0] DEF_ID_VALUE = 32'h444D_0001;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/dma_regfile_mp_if.sv
// Write and multi-port read bus of the DMA register file.
interface dma_regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RD     = 3
);
    logic                             wr_valid;
    logic                             wr_ready;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [DATA_WIDTH-1:0]            wr_data;
    logic [DATA_WIDTH/8-1:0]          wr_strb;
    logic [NUM_RD-1:0]                rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0]     rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0]     rd_data;
    logic [NUM_RD-1:0]                rd_valid;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/dma_regfile_rdport.sv
// One registered read port with write-first bypass of the same-cycle update.
module dma_regfile_rdport
    import dma_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] cur,
    input  logic                             wr_hit,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_word,
    input  logic [DATA_WIDTH-1:0]            status_nxt,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid
);
    logic                  is_status;
    logic                  is_byp;
    logic [DATA_WIDTH-1:0] sel;

    // STATUS changes every cycle via hw_set, so it always reads its next value
    always_comb begin
        is_status = (rd_addr == ADDR_WIDTH'(ADDR_STATUS));
        is_byp    = wr_hit && (rd_addr == wr_addr) && !is_status;
        sel       = cur[rd_addr];
        unique case (1'b1)
            is_status: sel = status_nxt;
            is_byp:    sel = wr_word;
            default:   sel = cur[rd_addr];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= sel;
        end
    end

endmodule

// File: rtl/dma_regfile_mp.sv
// DMA register file: ID, W1C STATUS, MASK and general registers, NUM_RD read ports.
module dma_regfile_mp
    import dma_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RD     = 3,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(DEF_ID_VALUE)
) (
    input  logic                  clk,
    input  logic                  rst,
    dma_regfile_mp_if.slave       bus,
    input  logic [DATA_WIDTH-1:0] hw_set,
    output logic                  irq
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    wr_state_e state;
    wr_state_e state_nxt;

    logic [DEPTH-1:1][DATA_WIDTH-1:0] regs;
    logic [DEPTH-1:1][DATA_WIDTH-1:0] nxt;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] cur;

    logic [DATA_WIDTH-1:0] bmask;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] clr;
    logic [DATA_WIDTH-1:0] status_nxt;
    logic                  wr_fire;
    logic                  wr_hit;

    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_p;
    logic [NUM_RD-1:0]                 rd_valid_p;

    always_ff @(posedge clk) begin
        if (rst)
            state <= INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        bus.wr_ready = (state == RUN) && !rst;
    end

    always_comb begin
        cur[0] = ID_VALUE;
        for (int i = 1; i < DEPTH; i++)
            cur[i] = regs[i];
    end

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++)
            bmask[b*8 +: 8] = {8{bus.wr_strb[b]}};
    end

    // ID is constant, so a write to it never counts as a hit
    always_comb begin
        wr_fire = bus.wr_valid && bus.wr_ready;
        wr_hit  = wr_fire && (bus.wr_addr != ADDR_WIDTH'(ADDR_ID));
        wr_word = (cur[bus.wr_addr] & ~bmask) | (bus.wr_data & bmask);
        clr     = '0;
        if (wr_fire && bus.wr_addr == ADDR_WIDTH'(ADDR_STATUS))
            clr = bus.wr_data & bmask;
        status_nxt = (cur[ADDR_STATUS] & ~clr) | hw_set;
    end

    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            nxt[i] = regs[i];
            if (wr_hit && bus.wr_addr == ADDR_WIDTH'(i))
                nxt[i] = wr_word;
        end
        nxt[ADDR_STATUS] = status_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
            irq  <= 1'b0;
        end else begin
            regs <= nxt;
            irq  <= |(status_nxt & nxt[ADDR_MASK]);
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        dma_regfile_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH)
        ) u_port (
            .clk        (clk),
            .rst        (rst),
            .rd_en      (bus.rd_en[p]),
            .rd_addr    (bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .cur        (cur),
            .wr_hit     (wr_hit),
            .wr_addr    (bus.wr_addr),
            .wr_word    (wr_word),
            .status_nxt (status_nxt),
            .rd_data    (rd_data_p[p]),
            .rd_valid   (rd_valid_p[p])
        );
    end

    assign bus.rd_data  = rd_data_p;
    assign bus.rd_valid = rd_valid_p;

endmodule

// File: doc/dma_regfile_mp.md
DMA_REGFILE_MP -- requirements
Module: dma_regfile_mp

Parameters
REQ-001 DATA_WIDTH, 32: register width; SHALL be a multiple of 8.
REQ-002 ADDR_WIDTH, 4: address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 NUM_RD, 3: number of independent read ports; SHALL be 1 to 8.
REQ-004 ID_VALUE, 32'h444D_0001: constant returned by the ID register.

Interface
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_valid  in  1  write request.
REQ-008 wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-009 wr_addr  in  ADDR_WIDTH  write address.
REQ-010 wr_data  in  DATA_WIDTH  write data.
REQ-011 wr_strb  in  DATA_WIDTH/8  byte enables for the write.
REQ-012 rd_en  in  NUM_RD  per-port read request.
REQ-013 rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 rd_data  out  NUM_RD*DATA_WIDTH  packed read data, using the same slicing as rd_addr.
REQ-015 rd_valid  out  NUM_RD  per-port data-valid pulse.
REQ-016 hw_set  in  DATA_WIDTH  hardware status-set bits.
REQ-017 irq  out  1  interrupt, equal to |(STATUS & MASK).

Function
REQ-018 Address map: 0 is ID (read-only); 1 is STATUS (W1C); 2 is MASK (RW); 3..DEPTH-1 are general RW.
REQ-019 An accepted write SHALL update only the bytes with wr_strb=1, one cycle after acceptance.
REQ-020 Writes to ID SHALL be ignored; reads of ID SHALL return ID_VALUE.
REQ-021 A STATUS write SHALL clear each bit written 1 in a strobed byte; bits written 0 SHALL be unchanged.
REQ-022 Every cycle, STATUS bits SHALL be ORed with hw_set.
REQ-023 If hw_set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-024 Read latency SHALL be 1 cycle: rd_en[p] at cycle N gives rd_valid[p]=1 and valid rd_data[p] at cycle N+1.
REQ-025 rd_data[p] SHALL hold its last value while rd_en[p]=0.
REQ-026 rd_valid[p] SHALL be 0 in any cycle not preceded by rd_en[p].
REQ-027 All read ports SHALL operate concurrently, including several ports on the same address.
REQ-028 Write-first collision: a read of an address accepted for write in the same cycle SHALL return the post-write value, strobes and W1C/hw_set rules applied.
REQ-029 irq SHALL be registered, reflecting STATUS and MASK as updated in the previous cycle.
REQ-030 wr_ready state machine: INIT goes to RUN on the first cycle with rst=0; RUN returns to INIT on rst.
REQ-031 wr_ready SHALL be 0 in INIT and 1 in RUN.
REQ-032 wr_valid with wr_ready=0 SHALL have no effect; the requester holds the request.
REQ-033 Out-of-range data widths SHALL NOT occur: all addresses decode, and no X SHALL be produced for any address.

Reset
REQ-034 On rst, all registers, STATUS and MASK SHALL clear to 0.
REQ-035 On rst, rd_data, rd_valid, irq and wr_ready SHALL be 0.
REQ-036 rst asserted mid-operation SHALL drop any same-cycle write and read, with no rd_valid the following cycle.
REQ-037 ID SHALL be unaffected by reset.

Structure
REQ-038 Package dma_regfile_pkg SHALL hold the ADDR_ID, ADDR_STATUS and ADDR_MASK constants, the default ID_VALUE, and the wr_ready state enum (INIT, RUN).
REQ-039 A single sub-module dma_regfile_rdport SHALL implement one read port (registered data, valid and bypass mux), instantiated NUM_RD times via generate.
REQ-040 Storage SHALL be a flop array, not inferred RAM, because of synchronous clear and multiple read ports.

Verification
REQ-041 Reset then wait: wr_ready=0 during rst and 1 one cycle after release; read addr 0 returns 32'h444D_0001, with rd_valid one cycle after rd_en.
REQ-042 Write 32'hAABBCCDD to addr 5 with strb=4'b0101, then read: returns 32'h00BB00DD.
REQ-043 Write addr 7 = 32'h12345678 while ports 0 and 2 read addr 7 in the same cycle: both return 32'h12345678 next cycle; port 1 reading addr 3 returns 0.
REQ-044 hw_set=32'h5 for one cycle, then MASK=32'h4: irq=1; W1C write 32'h4 to STATUS gives STATUS=1 and irq=0.
REQ-045 Same-cycle hw_set=32'h1 and W1C 32'h1: STATUS bit0 stays 1.
REQ-046 Assert rst during a pending write and rd_en: the write is lost, rd_valid=0 the next cycle, and all reads return 0 afterwards.
